// File: rtl/iterative_shifter_pkg.sv
// Shared encodings for the iterative shifter; the ALU control decoder
// reuses the op codes defined here.
package iterative_shifter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b10;  // reserved, behaves as SRL
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// Single combinational shift step: moves data by n (0..STEP) positions,
// left with zero fill or right with the supplied fill bit.
module iterative_shifter_shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int NW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [NW-1:0]    n_i,
  input  logic [1:0]       op_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    data_o = data_i;
    for (int k = 1; k <= STEP; k++) begin
      if (n_i == NW'(k)) begin
        if (op_i == OP_SLL) begin
          data_o = data_i << k;
        end else begin
          data_o = (data_i >> k) | ({WIDTH{fill_i}} & ~({WIDTH{1'b1}} >> k));
        end
      end
    end
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA unit: shifts STEP positions per cycle with a
// start/busy/done handshake so the ALU path avoids a full barrel shifter.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1   // power of two, 1..16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int NW = $clog2(STEP + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [4:0]       rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             fill_q, fill_d;
  logic [NW-1:0]    n;
  logic [WIDTH-1:0] stepped;

  // When fewer than STEP positions remain, the remainder fits in NW bits.
  always_comb begin
    n = (rem_q >= 5'(STEP)) ? NW'(STEP) : NW'(rem_q);
  end

  iterative_shifter_shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .data_i(work_q),
    .n_i   (n),
    .op_i  (op_q),
    .fill_i(fill_q),
    .data_o(stepped)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    rem_d   = rem_q;
    op_d    = op_q;
    fill_d  = fill_q;
    case (state_q)
      ST_SHIFT: begin
        work_d = stepped;
        rem_d  = rem_q - 5'(n);
        if (rem_d == 5'd0) begin
          state_d = ST_DONE;
          out_d   = stepped;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE gives back-to-back issue.
        state_d = ST_IDLE;
        if (start) begin
          op_d   = op;
          fill_d = (op == OP_SRA) && in[WIDTH-1];
          work_d = in;
          rem_d  = shamt;
          if (shamt == 5'd0) begin
            state_d = ST_DONE;
            out_d   = in;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_SLL;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter: a STEP=1 and a STEP=4 instance
// driven from one linear sequence with hand-computed expectations.
module tb_iterative_shifter;

  logic        Clk;
  logic        Rst;
  logic        start1, start4;
  logic [1:0]  op;
  logic [31:0] in_d;
  logic [4:0]  shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] out1, out4;

  int checks = 0;
  int errors = 0;

  iterative_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .start(start1), .op(op), .in(in_d), .shamt(shamt),
    .busy(busy1), .done(done1), .out(out1)
  );

  iterative_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .start(start4), .op(op), .in(in_d), .shamt(shamt),
    .busy(busy4), .done(done4), .out(out4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one operation, then count latency and busy cycles up to done.
  task automatic run_op(input bit wide4, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_out,
                        input int exp_lat, input int exp_busy, input string tag);
    int lat;
    int busy_cnt;
    op    = o;
    in_d  = d;
    shamt = s;
    if (wide4) start4 = 1'b1;
    else       start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
    in_d   = ~d;
    op     = ~o;
    shamt  = ~s;
    lat      = 1;
    busy_cnt = 0;
    while (!(wide4 ? done4 : done1) && lat < 100) begin
      if (wide4 ? busy4 : busy1) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy_cnt, exp_busy);
    check({tag, "_out"}, wide4 ? out4 : out1, exp_out);
    tick();
    check({tag, "_pulse"}, {31'd0, wide4 ? done4 : done1}, 32'd0);
    check({tag, "_hold"}, wide4 ? out4 : out1, exp_out);
  endtask

  initial begin
    int lat;
    bit seen;
    Rst    = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    op     = 2'b00;
    in_d   = '0;
    shamt  = '0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_out", out1, 32'd0);
    check("rst_out4", out4, 32'd0);
    Rst = 1'b1;
    tick();

    run_op(1'b0, 2'b00, 32'd1,          5'd4,  32'd16,         5,  4,  "sll4");
    run_op(1'b0, 2'b01, 32'hDEAD_BEEF,  5'd0,  32'hDEAD_BEEF,  1,  0,  "zero");
    run_op(1'b0, 2'b11, 32'h8000_0000,  5'd31, 32'hFFFF_FFFF,  32, 31, "sra31");
    run_op(1'b0, 2'b01, 32'h8000_0000,  5'd31, 32'h0000_0001,  32, 31, "srl31");
    run_op(1'b0, 2'b10, 32'h8000_0000,  5'd3,  32'h1000_0000,  4,  3,  "rsv3");
    run_op(1'b0, 2'b11, 32'h7000_0000,  5'd2,  32'h1C00_0000,  3,  2,  "sra_pos");

    // Back-to-back issue from DONE, with a start pulse during SHIFT ignored.
    op     = 2'b01;
    in_d   = 32'h0000_00F0;
    shamt  = 5'd4;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    start1 = 1'b1;
    op     = 2'b00;
    in_d   = 32'hFFFF_FFFF;
    shamt  = 5'd1;
    tick();
    start1 = 1'b0;
    lat = 3;
    while (!done1 && lat < 100) begin
      tick();
      lat++;
    end
    check("b2b_lat1", lat, 5);
    check("b2b_out1", out1, 32'h0000_000F);
    op     = 2'b00;
    in_d   = 32'd3;
    shamt  = 5'd1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("b2b_busy", {31'd0, busy1}, 32'd1);
    lat = 1;
    while (!done1 && lat < 100) begin
      tick();
      lat++;
    end
    check("b2b_lat2", lat, 2);
    check("b2b_out2", out1, 32'd6);
    tick();

    // Reset during a long shift abandons it with no done pulse.
    op     = 2'b01;
    in_d   = 32'hFFFF_FFFF;
    shamt  = 5'd20;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    check("mid_busy", {31'd0, busy1}, 32'd1);
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    check("mid_rst_busy", {31'd0, busy1}, 32'd0);
    check("mid_rst_done", {31'd0, done1}, 32'd0);
    check("mid_rst_out", out1, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done1 || busy1) seen = 1'b1;
    end
    check("mid_no_done", {31'd0, seen}, 32'd0);

    run_op(1'b1, 2'b11, 32'hF000_0000,  5'd9,  32'hFFF8_0000,  4,  3,  "s4_sra9");
    run_op(1'b1, 2'b00, 32'h0000_ABCD,  5'd16, 32'hABCD_0000,  5,  4,  "s4_sll16");
    run_op(1'b1, 2'b01, 32'h8000_0000,  5'd31, 32'h0000_0001,  9,  8,  "s4_srl31");
    run_op(1'b1, 2'b00, 32'h1234_5678,  5'd0,  32'h1234_5678,  1,  0,  "s4_zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
